// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one synchronous FIFO write
// port among NREQ valid/ready producers. A granted producer keeps the port for
// up to MAX_BURST beats. Write enable and write data are driven from registers,
// and the arbiter throttles on full / almost-full so a full FIFO is never written.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DATA_W-1:0]   i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic                     i_full,
  input  logic                     i_alm_full,
  output logic                     o_wren,
  output logic [DATA_W-1:0]        o_wrdata,
  output logic [NREQ-1:0]          o_grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_BURST = 1'b1;
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [PTR_W:0]   NREQ_EXT = (PTR_W + 1)'(NREQ);

  // one-hot decode of a requester index
  function automatic logic [NREQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [0:0]        r_state;
  logic [PTR_W-1:0]  r_owner;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [PTR_W-1:0]  r_last_ptr;
  logic              r_wren;
  logic [DATA_W-1:0] r_wrdata;
  logic [NREQ-1:0]   r_grant;

  logic              w_can_write;
  logic              w_found;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W:0]    w_sum;
  logic [NREQ-1:0]   w_ready;
  logic              w_xfer;
  logic [PTR_W-1:0]  w_xfer_idx;
  logic [DATA_W-1:0] w_xfer_data;
  logic [0:0]        w_state_nx;
  logic [PTR_W-1:0]  w_owner_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [PTR_W-1:0]  w_last_nx;

  // write allowed unless full, or almost-full with a write already in flight
  always_comb begin
    w_can_write = ~i_full & ~(i_alm_full & r_wren);
  end

  // round-robin search: first valid requester after last_ptr, modulo NREQ
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_ptr;
    w_sum    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = {1'b0, r_last_ptr} + (PTR_W + 1)'(i);
      if (w_sum >= NREQ_EXT) begin
        w_sum = w_sum - NREQ_EXT;
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && i_req_valid[w_sum[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[PTR_W-1:0];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // burst FSM next state, ready generation and transfer detection
  always_comb begin
    w_ready    = '0;
    w_xfer     = 1'b0;
    w_xfer_idx = r_owner;
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_beat_cnt;
    w_last_nx  = r_last_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found && w_can_write) begin
          w_ready[w_winner] = 1'b1;
          w_xfer            = 1'b1;
          w_xfer_idx        = w_winner;
          if (MAX_BURST == 1) begin
            // single-beat bursts: rotate immediately, never enter BURST
            w_last_nx = w_winner;
          end else begin
            w_state_nx = ST_BURST;
            w_owner_nx = w_winner;
            w_cnt_nx   = CNT_W'(1);
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_BURST: begin
        w_ready[r_owner] = w_can_write;
        if (!i_req_valid[r_owner]) begin
          // owner released: a valid drop wins over any can_write stall
          w_state_nx = ST_IDLE;
          w_last_nx  = r_owner;
        end else if (w_can_write) begin
          w_xfer   = 1'b1;
          w_cnt_nx = r_beat_cnt + CNT_W'(1);
          if ((r_beat_cnt + CNT_W'(1)) == CNT_MAX) begin
            w_state_nx = ST_IDLE;
            w_last_nx  = r_owner;
          end else begin
            w_state_nx = ST_BURST;
          end
        end else begin
          // stall: owner and beat count hold
          w_state_nx = ST_BURST;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_last_nx  = LAST_RST;
      end
    endcase
  end

  // ready is forced low while reset is asserted so no beat is lost
  always_comb begin
    if (!rstn) begin
      o_req_ready = '0;
    end else begin
      o_req_ready = w_ready;
    end
  end

  // select the transferring requester's data
  always_comb begin
    w_xfer_data = i_req_data[w_xfer_idx*DATA_W +: DATA_W];
  end

  // state, grant and FIFO write registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_last_ptr <= LAST_RST;
      r_wren     <= 1'b0;
      r_wrdata   <= '0;
      r_grant    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_beat_cnt <= w_cnt_nx;
      r_last_ptr <= w_last_nx;
      r_wren     <= w_xfer;
      if (w_xfer) begin
        r_wrdata <= w_xfer_data;
      end else begin
        r_wrdata <= r_wrdata;
      end
      if (w_state_nx == ST_BURST) begin
        r_grant <= f_onehot(w_owner_nx);
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign o_wren   = r_wren;
  assign o_wrdata = r_wrdata;
  assign o_grant  = r_grant;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among NREQ producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for bursts of up to MAX_BURST beats and drives the FIFO's write enable and write data from a register. It throttles on the FIFO's full and almost-full flags so the FIFO is never written while full.

## Interface

- NREQ, 4, number of requesters (2..16)
- DATA_W, 128, data width; equals the FIFO data width
- MAX_BURST, 4, maximum consecutive beats per grant (1..256)

- clk  input  1  clock; all logic on rising edge
- rstn  input  1  active-low synchronous reset
- i_req_valid  input  NREQ  per-requester valid
- i_req_data  input  NREQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W]
- o_req_ready  output  NREQ  per-requester ready; combinational
- i_full  input  1  FIFO full
- i_alm_full  input  1  FIFO almost-full
- o_wren  output  1  FIFO write enable; registered
- o_wrdata  output  DATA_W  FIFO write data; registered
- o_grant  output  NREQ  one-hot current burst owner; registered; 0 when idle

## Operation

- A beat transfers on requester k when i_req_valid[k] && o_req_ready[k].
- can_write = !i_full && !(i_alm_full && o_wren).
  - The FIFO almost-full threshold must leave at least 2 free entries. This covers the one write in flight.
- State registers: state (IDLE/BURST), owner (log2 NREQ), beat_cnt (log2(MAX_BURST)+1), last_ptr (reset NREQ-1).
- IDLE:
  - If any valid and can_write, the winner is the first valid requester searching last_ptr+1, last_ptr+2, … modulo NREQ.
  - o_req_ready[winner]=1 and the beat transfers that cycle.
  - Next state: BURST with owner=winner, beat_cnt=1.
  - Exception: if MAX_BURST==1, stay in IDLE with last_ptr=winner.
  - If no valid, or can_write=0: all ready=0 and the state holds.
- BURST:
  - o_req_ready[owner]=can_write; all other ready bits are 0.
  - On transfer: beat_cnt+1. If it reaches MAX_BURST: go to IDLE, last_ptr=owner.
  - If i_req_valid[owner]=0: no transfer; go to IDLE, last_ptr=owner. Release costs one idle cycle.
  - If can_write=0 with valid high: hold owner and beat_cnt (stall). The stall does not count toward the burst.
- Write path: each transfer registers o_wren=1 and o_wrdata=transferred data on the next edge.
  - With no transfer, o_wren=0 and o_wrdata holds its value.
- o_grant = one-hot(owner) while in BURST, else 0. Registered together with state.
- Requester data must be stable while valid is high and ready is low. The arbiter does not check this.

## Timing

- Reset (rstn=0 at edge): state=IDLE, last_ptr=NREQ-1, beat_cnt=0, o_wren=0, o_wrdata=0, o_grant=0.
  - o_req_ready=0 combinationally while rstn=0.
- Reset mid-burst drops the burst. Any beat accepted in the reset cycle is not written.
- Latency: transfer at edge N gives o_wren=1 in cycle N+1, so the FIFO writes at edge N+1.
- Throughput: 1 beat/cycle within a burst. There is 0 turnaround cycles on burst-count completion: the next IDLE cycle arbitrates and can transfer.
- Full: i_full=1 forces all ready=0 that same cycle. o_wren is never 1 in a cycle where i_full was 1 at the preceding transfer decision.
- Almost-full: i_alm_full=1 allows at most one write every other cycle. The arbiter never issues back-to-back writes under almost-full.
- A valid drop from the owner and a can_write drop in the same cycle release the owner (valid drop wins).
- last_ptr wraps modulo NREQ. NREQ not a power of two must wrap correctly (e.g. NREQ=3: 2→0).

## Test plan

- Reset then single requester: NREQ=4, MAX_BURST=4, valid[2]=1 for 6 beats with data 0x10..0x15.
  - Required: two bursts (4+2 beats). o_wrdata sequence 0x10..0x15, each one cycle after its transfer. o_grant=4'b0100 during bursts.
- All four requesters valid continuously, FIFO never full.
  - Required: grant order 0,1,2,3,0,… with 4 beats each, o_wren=1 every cycle, no idle gap.
- i_full=1 asserted mid-burst after beat 2 for 5 cycles.
  - Required: ready=0 and o_wren=0 during stall.
  - After release: same owner resumes, beats 3–4 complete, then the grant rotates.
- i_alm_full=1 held, requester 1 streaming.
  - Required: o_wren pattern 1,0,1,0…, and no write while i_full=1.
- Owner deasserts valid after 1 beat while requester 3 is valid.
  - Required: one idle cycle, then grant to 3. last_ptr=owner so the next round starts after the owner.
- rstn=0 for one cycle mid-burst.
  - Required: next cycle o_grant=0, o_wren=0, and arbitration restarts at requester 0.
